aes_result_checker: RTL and testbench
=====================================

// Module: aes_result_checker
// PURPOSE
//  Response-side checker for the AES-128 core handshake (start/decrypt request, data_o/ready_o result).
//  Watches each request, waits for the core's result strobe and compares the 128-bit result to an expected
//  value selected by the request mode (encrypt/decrypt). Keeps pass/fail counters and sticky protocol errors.
//  Sits beside aes_top in self-test builds; its outputs feed status registers or LEDs.
// PARAMETERS
//  EXP_ENC   128'h0   expected result for an encrypt request (decrypt_i=0 at start)
//  EXP_DEC   128'h0   expected result for a decrypt request (decrypt_i=1 at start)
//  TIMEOUT   1024     max cycles in WAIT before a timeout is declared (>=2)
//  CNT_W     16       width of pass/fail counters
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start_i      in   1      request strobe sent to the core (1-cycle pulse)
//  decrypt_i    in   1      mode sent with start_i; 1=decrypt
//  vld_i        in   1      core result valid (ready_o), 1-cycle pulse
//  data_i       in   128    core result (data_o), sampled when vld_i=1
//  clr_i        in   1      synchronous clear of counters and err_o
//  busy_o       out  1      1 while in WAIT
//  pass_o       out  1      1-cycle pulse: result matched
//  fail_o       out  1      1-cycle pulse: mismatch or timeout
//  pass_cnt_o   out  CNT_W  number of passed requests, saturating
//  fail_cnt_o   out  CNT_W  number of failed requests (mismatch+timeout), saturating
//  err_o        out  4      sticky: [0] mismatch [1] timeout [2] start while busy [3] vld while idle
//  last_o       out  128    last sampled data_i
// BEHAVIOUR
//  Reset: FSM=IDLE, timer=0, mode=0; all outputs 0.
//  FSM states IDLE, WAIT.
//   IDLE: start_i=1 -> latch mode<=decrypt_i, timer<=0, go WAIT. vld_i=1 (no start) -> err_o[3]<=1, stay.
//         start_i and vld_i same cycle in IDLE: start accepted, err_o[3] set.
//   WAIT: vld_i=1 -> last_o<=data_i; compare data_i vs (mode?EXP_DEC:EXP_ENC), full 128 bits;
//         equal -> pass_o=1, pass_cnt_o+1; else fail_o=1, fail_cnt_o+1, err_o[0]<=1; go IDLE.
//         else if timer==TIMEOUT-1 -> fail_o=1, fail_cnt_o+1, err_o[1]<=1, go IDLE.
//         else timer<=timer+1.
//         start_i=1 in WAIT -> ignored (mode/timer unchanged), err_o[2]<=1.
//   vld_i and timer==TIMEOUT-1 same cycle: vld_i wins (compared normally, no timeout).
//  Latency: vld_i sampled at edge N -> pass_o/fail_o, counters, last_o, err_o updated at edge N;
//   pass_o/fail_o high exactly one cycle. pass_o and fail_o never high together.
//  Timeout: with start at edge S and no vld_i, fail_o is asserted after edge S+TIMEOUT.
//  busy_o registered: 1 from edge after start accept through the edge that returns to IDLE.
//  Counters saturate at 2^CNT_W-1, no wrap. Timer width = clog2(TIMEOUT).
//  clr_i: counters and err_o <= 0; clr_i wins over same-cycle increment/set; FSM, last_o,
//   pass_o/fail_o unaffected.
//  rst_n low mid-WAIT: immediate return to reset state; a pending request is dropped uncounted.
// TESTING
//  T1 EXP_ENC=128'h1234..EF: start_i, decrypt_i=0, vld_i 20 cyc later data_i=EXP_ENC -> pass_o 1 cyc, pass_cnt_o=1, err_o=0.
//  T2 decrypt_i=1, data_i=EXP_DEC^128'h1 -> fail_o 1 cyc, fail_cnt_o=1, err_o=4'b0001, last_o=data_i.
//  T3 TIMEOUT=8, start, no vld_i -> fail_o 8 cyc after start edge, err_o[1]=1, busy_o drops; vld on cycle 8 -> pass instead.
//  T4 second start_i while busy -> err_o[2]=1, mode unchanged; vld_i while idle -> err_o[3]=1, no counter change.
//  T5 CNT_W=2: 5 passing requests -> pass_cnt_o=3 (saturated); clr_i with same-cycle pass -> counters/err_o=0.
//  T6 rst_n pulsed low mid-WAIT -> all outputs 0 async, later vld_i only sets err_o[3].

Source files
------------

// File: rtl/aes_result_checker.sv
// Response-side checker for the AES-128 core handshake: matches each result against the
// expected encrypt/decrypt vector, counts pass/fail and keeps sticky protocol errors.
module aes_result_checker #(
    parameter logic [127:0] EXP_ENC = 128'h0,
    parameter logic [127:0] EXP_DEC = 128'h0,
    parameter int           TIMEOUT = 1024,
    parameter int           CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic             vld_i,
    input  logic [127:0]     data_i,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [3:0]       err_o,
    output logic [127:0]     last_o
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]    TMAX    = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [3:0]         err_q, err_d;
    logic [127:0]       last_q, last_d;
    logic [127:0]       exp_w;

    assign exp_w = mode_q ? EXP_DEC : EXP_ENC;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        mode_d     = mode_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        err_d      = err_q;
        last_d     = last_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d  = decrypt_i;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                if (vld_i) err_d[3] = 1'b1;
            end
            default: begin
                // A second start is only flagged; the outstanding request keeps its mode/timer.
                if (start_i) err_d[2] = 1'b1;
                if (vld_i) begin
                    last_d  = data_i;
                    state_d = S_IDLE;
                    if (data_i == exp_w) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d   = 1'b1;
                        err_d[0] = 1'b1;
                    end
                end else if (timer_q == TMAX) begin
                    fail_d   = 1'b1;
                    err_d[1] = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        endcase
        if (pass_d && pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        if (fail_d && fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        if (clr_i) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_d      = '0;
        end
        busy_d = (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_q      <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            err_q      <= err_d;
            last_q     <= last_d;
        end
    end

    assign busy_o     = busy_q;
    assign pass_o     = pass_q;
    assign fail_o     = fail_q;
    assign pass_cnt_o = pass_cnt_q;
    assign fail_cnt_o = fail_cnt_q;
    assign err_o      = err_q;
    assign last_o     = last_q;
endmodule

// File: tb/tb_aes_result_checker.sv
// Directed bench: instance A (TIMEOUT=32, CNT_W=16) for compare/protocol/reset cases,
// instance B (TIMEOUT=8, CNT_W=2) for timeout and saturation cases.
module tb_aes_result_checker;
    localparam logic [127:0] ENC = 128'h123456789abcdef0_fedcba9876543210;
    localparam logic [127:0] DEC = 128'hdeadbeefcafebabe_0011223344556677;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sel = 1'b0, start = 1'b0, dec = 1'b0, vld = 1'b0, clr = 1'b0;
    logic [127:0] data = '0;

    logic busy_a, pass_a, fail_a;
    logic [15:0] pc_a, fc_a;
    logic [3:0] err_a;
    logic [127:0] last_a;
    logic busy_b, pass_b, fail_b;
    logic [1:0] pc_b, fc_b;
    logic [3:0] err_b;
    logic [127:0] last_b;

    aes_result_checker #(.EXP_ENC(ENC), .EXP_DEC(DEC), .TIMEOUT(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start & ~sel), .decrypt_i(dec),
        .vld_i(vld & ~sel), .data_i(data), .clr_i(clr & ~sel),
        .busy_o(busy_a), .pass_o(pass_a), .fail_o(fail_a), .pass_cnt_o(pc_a),
        .fail_cnt_o(fc_a), .err_o(err_a), .last_o(last_a));

    aes_result_checker #(.EXP_ENC(ENC), .EXP_DEC(DEC), .TIMEOUT(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start & sel), .decrypt_i(dec),
        .vld_i(vld & sel), .data_i(data), .clr_i(clr & sel),
        .busy_o(busy_b), .pass_o(pass_b), .fail_o(fail_b), .pass_cnt_o(pc_b),
        .fail_cnt_o(fc_b), .err_o(err_b), .last_o(last_b));

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         dec;
        logic [127:0] data;
        int           delay;
        logic         pass;
        logic [3:0]   err;
    } vec_t;

    vec_t tbl[6];
    int   pc_exp, fc_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, ENC,                       20, 1'b1, 4'b0000};
        tbl[1] = '{1'b1, DEC ^ 128'h1,               5, 1'b0, 4'b0001};
        tbl[2] = '{1'b1, DEC,                        1, 1'b1, 4'b0001};
        tbl[3] = '{1'b0, DEC,                        3, 1'b0, 4'b0001};
        tbl[4] = '{1'b0, ENC ^ {1'b1, 127'h0},      31, 1'b0, 4'b0001};
        tbl[5] = '{1'b1, DEC,                       32, 1'b1, 4'b0001};

        // reset state (async, while held low)
        #12;
        chk("rst busy", 128'(busy_a), 128'(0));
        chk("rst pass/fail", 128'({pass_a, fail_a, pass_b, fail_b}), 128'(0));
        chk("rst cnt", 128'({pc_a, fc_a, pc_b, fc_b}), 128'(0));
        chk("rst err", 128'({err_a, err_b}), 128'(0));
        chk("rst last", last_a, 128'(0));
        rst_n = 1'b1;
        tick;

        // table-driven requests on A
        pc_exp = 0; fc_exp = 0;
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; dec = tbl[i].dec;
            tick;
            start = 1'b0;
            chk($sformatf("v%0d busy", i), 128'(busy_a), 128'(1));
            repeat (tbl[i].delay - 1) tick;
            vld = 1'b1; data = tbl[i].data;
            tick;
            vld = 1'b0;
            if (tbl[i].pass) pc_exp++; else fc_exp++;
            chk($sformatf("v%0d pass", i), 128'(pass_a), 128'(tbl[i].pass));
            chk($sformatf("v%0d fail", i), 128'(fail_a), 128'(!tbl[i].pass));
            chk($sformatf("v%0d pass_cnt", i), 128'(pc_a), 128'(pc_exp));
            chk($sformatf("v%0d fail_cnt", i), 128'(fc_a), 128'(fc_exp));
            chk($sformatf("v%0d err", i), 128'(err_a), 128'(tbl[i].err));
            chk($sformatf("v%0d last", i), last_a, tbl[i].data);
            tick;
            chk($sformatf("v%0d pulse drop", i), 128'({pass_a, fail_a, busy_a}), 128'(0));
        end

        // T4: start while busy keeps mode, vld while idle only flags
        clr = 1'b1; tick; clr = 1'b0;
        chk("clr cnt", 128'({pc_a, fc_a}), 128'(0));
        chk("clr err", 128'(err_a), 128'(0));
        start = 1'b1; dec = 1'b1; tick;
        dec = 1'b0; tick;
        start = 1'b0;
        chk("busy start err", 128'(err_a), 128'(4'b0100));
        chk("busy still", 128'(busy_a), 128'(1));
        tick;
        vld = 1'b1; data = DEC; tick; vld = 1'b0;
        chk("mode kept pass", 128'({pass_a, fail_a}), 128'(2'b10));
        chk("mode kept cnt", 128'(pc_a), 128'(1));
        tick;
        vld = 1'b1; data = ENC; tick; vld = 1'b0;
        chk("idle vld err", 128'(err_a), 128'(4'b1100));
        chk("idle vld cnt", 128'({pc_a, fc_a}), 128'({16'd1, 16'd0}));
        chk("idle vld pulses", 128'({pass_a, fail_a, busy_a}), 128'(0));
        chk("idle vld last", last_a, DEC);

        // T3 on B: timeout after TIMEOUT cycles
        sel = 1'b1;
        start = 1'b1; dec = 1'b0; tick; start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick;
            chk($sformatf("to wait%0d", k), 128'({busy_b, fail_b}), 128'(2'b10));
        end
        tick;
        chk("to fail", 128'({fail_b, pass_b, busy_b}), 128'(3'b100));
        chk("to err", 128'(err_b), 128'(4'b0010));
        chk("to fcnt", 128'(fc_b), 128'(1));
        tick;
        chk("to drop", 128'(fail_b), 128'(0));
        // vld exactly on the timeout cycle wins
        start = 1'b1; tick; start = 1'b0;
        repeat (7) tick;
        vld = 1'b1; data = ENC; tick; vld = 1'b0;
        chk("to vld wins", 128'({pass_b, fail_b}), 128'(2'b10));
        chk("to vld cnt", 128'({pc_b, fc_b}), 128'({2'd1, 2'd1}));
        chk("to vld err", 128'(err_b), 128'(4'b0010));

        // T5: saturation, then clr beating a same-cycle pass
        for (int n = 2; n <= 5; n++) begin
            start = 1'b1; tick; start = 1'b0;
            tick;
            vld = 1'b1; data = ENC; tick; vld = 1'b0;
            chk($sformatf("sat pass%0d", n), 128'(pc_b), 128'((n > 3) ? 3 : n));
        end
        start = 1'b1; tick; start = 1'b0;
        vld = 1'b1; data = ENC; clr = 1'b1; tick; vld = 1'b0; clr = 1'b0;
        chk("clr+pass pulse", 128'(pass_b), 128'(1));
        chk("clr+pass cnt", 128'({pc_b, fc_b}), 128'(0));
        chk("clr+pass err", 128'(err_b), 128'(0));

        // T6: async reset mid-WAIT on A
        sel = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", 128'({busy_a, pass_a, fail_a}), 128'(0));
        chk("arst cnt", 128'({pc_a, fc_a}), 128'(0));
        chk("arst err", 128'(err_a), 128'(0));
        chk("arst last", last_a, 128'(0));
        #2 rst_n = 1'b1;
        tick;
        vld = 1'b1; data = ENC; tick; vld = 1'b0;
        chk("post rst err", 128'(err_a), 128'(4'b1000));
        chk("post rst cnt", 128'({pc_a, fc_a, 13'd0, pass_a, fail_a, busy_a}), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
